// File: rtl/ltsm_link_monitor_pkg.sv
// Shared definitions for the LTSM link monitor: state encodings, default
// dwell limit and the event record layout.
package ltsm_pkg;

  localparam logic [2:0] ST_RESET      = 3'b000;
  localparam logic [2:0] ST_SBINIT     = 3'b001;
  localparam logic [2:0] ST_MBINIT     = 3'b010;
  localparam logic [2:0] ST_MBTRAIN    = 3'b011;
  localparam logic [2:0] ST_LINKINIT   = 3'b100;
  localparam logic [2:0] ST_ACTIVE     = 3'b101;
  localparam logic [2:0] ST_TRAINERROR = 3'b110;
  localparam logic [2:0] ST_NONE       = 3'b111;

  // 8 ms at 100 MHz
  localparam int DEFAULT_TIMEOUT_CYCLES = 800000;

  localparam int EVT_LINK_W  = 1;
  localparam int EVT_STATE_W = 3;
  localparam int EVT_TS_W    = 24;

  // Event record for the default two-link, 3-bit-state, 24-bit-timestamp build
  typedef struct packed {
    logic [EVT_LINK_W-1:0]  link;
    logic [EVT_STATE_W-1:0] state;
    logic [EVT_TS_W-1:0]    ts;
  } ltsm_evt_t;

endpackage

// File: rtl/ltsm_link_monitor_if.sv
// Event read-side bundle of the LTSM link monitor: show-ahead head fields,
// consumer ready and the sticky lost-event flag.
interface ltsm_link_monitor_if #(
  parameter int LINK_W  = 1,
  parameter int STATE_W = 3,
  parameter int TS_W    = 24
);
  logic               evt_valid_o;
  logic               evt_ready_i;
  logic [LINK_W-1:0]  evt_link_o;
  logic [STATE_W-1:0] evt_state_o;
  logic [TS_W-1:0]    evt_time_o;
  logic               evt_overflow_o;

  modport master (
    output evt_valid_o, evt_link_o, evt_state_o, evt_time_o, evt_overflow_o,
    input  evt_ready_i
  );

  modport slave (
    input  evt_valid_o, evt_link_o, evt_state_o, evt_time_o, evt_overflow_o,
    output evt_ready_i
  );
endinterface

// File: rtl/ltsm_event_fifo.sv
// Synchronous FIFO with push/full write side and show-ahead valid/ready
// read side; fullness is judged on the registered count only.
module ltsm_event_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 8
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  output logic             full,
  output logic             popValid,
  input  logic             popReady,
  output logic [WIDTH-1:0] popData
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [CNT_W-1:0] count;
   logic             doPush;
   logic             doPop;

   assign full     = (count == CNT_W'(DEPTH));
   assign popValid = (count != '0);
   assign popData  = mem[rdPtr];
   assign doPush   = push && !full;
   assign doPop    = popValid && popReady;

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else if (clear) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PTR_W'(1);
         if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
         case ({doPush, doPop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately left out of reset; emptiness comes from count,
   // so a reset or clear discards every entry without touching the array.
   always_ff @(posedge clk_100MHz) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/ltsm_link_monitor.sv
// Monitors NUM_LINKS link-training state machines: sticky ACTIVE/TRAINERROR/
// dwell-timeout flags and a timestamped log of every state change.
module ltsm_link_monitor
  import ltsm_pkg::*;
#(
  parameter int NUM_LINKS      = 2,
  parameter int STATE_W        = 3,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TS_W           = 24,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                         clk_100MHz,
  input  logic                         reset,
  input  logic                         enable_i,
  input  logic                         clear_i,
  input  logic [NUM_LINKS*STATE_W-1:0] ltsm_state_i,
  output logic [NUM_LINKS-1:0]         active_reached_o,
  output logic                         all_active_o,
  output logic [NUM_LINKS-1:0]         trainerror_seen_o,
  output logic [NUM_LINKS-1:0]         timeout_o,
  ltsm_link_monitor_if.master          evt
);
   localparam int LINK_W  = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;
   localparam int DWELL_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [STATE_W-1:0] S_RESET      = STATE_W'(ST_RESET);
   localparam logic [STATE_W-1:0] S_ACTIVE     = STATE_W'(ST_ACTIVE);
   localparam logic [STATE_W-1:0] S_TRAINERROR = STATE_W'(ST_TRAINERROR);
   localparam logic [STATE_W-1:0] S_NONE       = '1;

   typedef struct packed {
      logic [LINK_W-1:0]  link;
      logic [STATE_W-1:0] state;
      logic [TS_W-1:0]    ts;
   } evtWord_t;

   logic [TS_W-1:0]    tsCount;
   logic [STATE_W-1:0] curState  [NUM_LINKS];
   logic [STATE_W-1:0] prevState [NUM_LINKS];
   logic [STATE_W-1:0] pendState [NUM_LINKS];
   logic [TS_W-1:0]    pendTime  [NUM_LINKS];
   logic [DWELL_W-1:0] dwell     [NUM_LINKS];
   logic [NUM_LINKS-1:0] pendValid;
   logic [NUM_LINKS-1:0] exempt;
   logic [NUM_LINKS-1:0] pushSel;
   logic               fifoPush;
   logic               fifoFull;
   logic               overflow;
   evtWord_t           pushWord;
   evtWord_t           headWord;

   // NOTE: every always_comb output gets a default before any branch, so no
   // path can leave a value held and infer a latch.
   always_comb begin
      pushSel  = '0;
      fifoPush = 1'b0;
      pushWord = '0;
      for (int k = 0; k < NUM_LINKS; k++) begin
         curState[k] = ltsm_state_i[k*STATE_W +: STATE_W];
         exempt[k]   = (curState[k] == S_RESET) || (curState[k] == S_ACTIVE) ||
                       (curState[k] == S_TRAINERROR);
         // lowest link index wins; one push per cycle
         if (enable_i && !clear_i && !fifoFull && pendValid[k] && !fifoPush) begin
            pushSel[k] = 1'b1;
            fifoPush   = 1'b1;
            pushWord   = '{link: LINK_W'(k), state: pendState[k], ts: pendTime[k]};
         end
      end
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) tsCount <= '0;
      else       tsCount <= tsCount + TS_W'(1);
   end

   // NOTE: state registers use non-blocking assignments only, so every link
   // sees the pre-edge values of pendValid and pushSel regardless of loop order.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset || clear_i) begin
         for (int k = 0; k < NUM_LINKS; k++) begin
            prevState[k] <= S_NONE;
            pendState[k] <= '0;
            pendTime[k]  <= '0;
            dwell[k]     <= '0;
         end
         pendValid         <= '0;
         active_reached_o  <= '0;
         trainerror_seen_o <= '0;
         timeout_o         <= '0;
         overflow          <= 1'b0;
      end else if (enable_i) begin
         for (int k = 0; k < NUM_LINKS; k++) begin
            if (curState[k] == S_ACTIVE)     active_reached_o[k]  <= 1'b1;
            if (curState[k] == S_TRAINERROR) trainerror_seen_o[k] <= 1'b1;
            if (curState[k] != prevState[k]) begin
               prevState[k] <= curState[k];
               pendValid[k] <= 1'b1;
               pendState[k] <= curState[k];
               pendTime[k]  <= tsCount;
               dwell[k]     <= '0;
               // an unpushed pending event is overwritten and lost
               if (pendValid[k] && !pushSel[k]) overflow <= 1'b1;
            end else begin
               if (pushSel[k]) pendValid[k] <= 1'b0;
               if (!exempt[k]) begin
                  if (dwell[k] == DWELL_W'(TIMEOUT_CYCLES - 1)) timeout_o[k] <= 1'b1;
                  else                                           dwell[k] <= dwell[k] + DWELL_W'(1);
               end
            end
         end
      end
   end

   ltsm_event_fifo #(
      .WIDTH ($bits(evtWord_t)),
      .DEPTH (FIFO_DEPTH)
   ) eventFifo (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .clear      (clear_i),
      .push       (fifoPush),
      .pushData   (pushWord),
      .full       (fifoFull),
      .popValid   (evt.evt_valid_o),
      .popReady   (evt.evt_ready_i),
      .popData    (headWord)
   );

   assign all_active_o       = &active_reached_o;
   assign evt.evt_link_o     = headWord.link;
   assign evt.evt_state_o    = headWord.state;
   assign evt.evt_time_o     = headWord.ts;
   assign evt.evt_overflow_o = overflow;

endmodule

// File: tb/tb_ltsm_link_monitor.sv
// Directed bench for ltsm_link_monitor: expected events are queued as states are
// driven and compared as the consumer pops them.
module tb_ltsm_link_monitor;
   import ltsm_pkg::*;

   localparam int NUM_LINKS      = 2;
   localparam int STATE_W        = 3;
   localparam int TIMEOUT_CYCLES = 16;
   localparam int TS_W           = 24;
   localparam int FIFO_DEPTH     = 4;
   localparam int LINK_W         = 1;

   logic                         clk_100MHz = 1'b0;
   logic                         reset;
   logic                         enable_i;
   logic                         clear_i;
   logic [NUM_LINKS*STATE_W-1:0] ltsm_state_i;
   logic [NUM_LINKS-1:0]         active_reached_o;
   logic                         all_active_o;
   logic [NUM_LINKS-1:0]         trainerror_seen_o;
   logic [NUM_LINKS-1:0]         timeout_o;

   ltsm_link_monitor_if #(.LINK_W(LINK_W), .STATE_W(STATE_W), .TS_W(TS_W)) evtIf ();

   ltsm_link_monitor #(
      .NUM_LINKS      (NUM_LINKS),
      .STATE_W        (STATE_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TS_W           (TS_W),
      .FIFO_DEPTH     (FIFO_DEPTH)
   ) dut (
      .clk_100MHz        (clk_100MHz),
      .reset             (reset),
      .enable_i          (enable_i),
      .clear_i           (clear_i),
      .ltsm_state_i      (ltsm_state_i),
      .active_reached_o  (active_reached_o),
      .all_active_o      (all_active_o),
      .trainerror_seen_o (trainerror_seen_o),
      .timeout_o         (timeout_o),
      .evt               (evtIf)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   int               vectors;
   int               miscompares;
   int               popCount;
   ltsm_evt_t        expQ [$];
   logic [STATE_W-1:0] tbPrev [NUM_LINKS];
   logic [TS_W-1:0]  tbTs;

   // Reference timestamp: free-running count of edges since reset release
   always @(posedge clk_100MHz or posedge reset) begin
      if (reset) tbTs <= '0;
      else       tbTs <= tbTs + TS_W'(1);
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic ltsm_evt_t mkEvt(input logic link, input logic [2:0] state, input logic [TS_W-1:0] ts);
      ltsm_evt_t e;
      e.link  = link;
      e.state = state;
      e.ts    = ts;
      return e;
   endfunction

   // Consumer: samples late in the low phase, after all stimulus for the next edge is set
   always begin
      @(negedge clk_100MHz);
      #2;
      if (!reset && evtIf.evt_valid_o && evtIf.evt_ready_i) begin
         popCount++;
         check("evt_expected", 32'(expQ.size() != 0), 32'd1);
         if (expQ.size() != 0) begin
            ltsm_evt_t e;
            e = expQ.pop_front();
            check("evt_head", 32'({evtIf.evt_link_o, evtIf.evt_state_o, evtIf.evt_time_o}), 32'(e));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk_100MHz);
   endtask

   task automatic driveLinks(input logic [2:0] s0, input logic [2:0] s1, input bit logIt = 1'b1);
      @(negedge clk_100MHz);
      ltsm_state_i = {s1, s0};
      if (logIt && s0 != tbPrev[0]) expQ.push_back(mkEvt(1'b0, s0, tbTs));
      if (logIt && s1 != tbPrev[1]) expQ.push_back(mkEvt(1'b1, s1, tbTs));
      tbPrev[0] = s0;
      tbPrev[1] = s1;
   endtask

   task automatic expectRelog();
      expQ.push_back(mkEvt(1'b0, ltsm_state_i[2:0], tbTs));
      expQ.push_back(mkEvt(1'b1, ltsm_state_i[5:3], tbTs));
      tbPrev[0] = ltsm_state_i[2:0];
      tbPrev[1] = ltsm_state_i[5:3];
   endtask

   task automatic waitDrain(input string tag, input int budget);
      int n = 0;
      while (expQ.size() != 0 && n < budget) begin
         @(negedge clk_100MHz);
         n++;
      end
      check(tag, 32'(expQ.size()), 32'd0);
      #1 check({tag, "_fifo_empty"}, 32'(evtIf.evt_valid_o), 32'd0);
   endtask

   task automatic checkFlags(input string tag, input logic [1:0] act, input logic [1:0] te,
                             input logic [1:0] tmo, input logic ovf);
      check({tag, "_active"},     32'(active_reached_o),  32'(act));
      check({tag, "_all_active"}, 32'(all_active_o),      32'(&act));
      check({tag, "_trainerror"}, 32'(trainerror_seen_o), 32'(te));
      check({tag, "_timeout"},    32'(timeout_o),         32'(tmo));
      check({tag, "_overflow"},   32'(evtIf.evt_overflow_o), 32'(ovf));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      popCount    = 0;
      reset       = 1'b0;
      enable_i    = 1'b0;
      clear_i     = 1'b0;
      evtIf.evt_ready_i = 1'b1;
      ltsm_state_i = {ST_RESET, ST_RESET};
      tbPrev[0] = ST_NONE;
      tbPrev[1] = ST_NONE;

      // Reset values
      #1 reset = 1'b1;
      #2;
      checkFlags("rst", 2'b00, 2'b00, 2'b00, 1'b0);
      check("rst_valid", 32'(evtIf.evt_valid_o), 32'd0);

      // Walk both links to ACTIVE, 10 cycles per state
      idle(2);
      reset    = 1'b0;
      enable_i = 1'b1;
      expectRelog();
      for (int s = 1; s <= 5; s++) begin
         idle(9);
         driveLinks(3'(s), 3'(s));
      end
      waitDrain("walk_drain", 60);
      check("walk_events", 32'(popCount), 32'd12);
      checkFlags("walk", 2'b11, 2'b00, 2'b00, 1'b0);

      // Dwell timeout on link1 at MBINIT; link0 parked at ACTIVE
      driveLinks(ST_ACTIVE, ST_MBINIT);
      @(posedge clk_100MHz);
      repeat (TIMEOUT_CYCLES - 1) @(posedge clk_100MHz);
      #1 check("timeout_before_limit", 32'(timeout_o), 32'b00);
      @(posedge clk_100MHz);
      #1 check("timeout_at_limit", 32'(timeout_o), 32'b10);
      idle(100);
      #1 check("timeout_active_exempt", 32'(timeout_o), 32'b10);
      waitDrain("timeout_drain", 10);

      // TRAINERROR then clear: flags drop, FIFO empty, current states re-logged
      driveLinks(ST_ACTIVE, ST_TRAINERROR);
      idle(3);
      #1 check("trainerror_seen", 32'(trainerror_seen_o), 32'b10);
      waitDrain("te_drain", 10);
      @(negedge clk_100MHz);
      clear_i = 1'b1;
      @(negedge clk_100MHz);
      clear_i   = 1'b0;
      tbPrev[0] = ST_NONE;
      tbPrev[1] = ST_NONE;
      #1;
      checkFlags("clear", 2'b00, 2'b00, 2'b00, 1'b0);
      check("clear_valid", 32'(evtIf.evt_valid_o), 32'd0);
      expectRelog();
      idle(2);
      #1 check("relog_active", 32'(active_reached_o), 32'b01);
      check("relog_trainerror", 32'(trainerror_seen_o), 32'b10);
      waitDrain("relog_drain", 10);

      // Overflow: 6 changes 2 cycles apart into a 4-deep FIFO with no consumer
      @(negedge clk_100MHz);
      evtIf.evt_ready_i = 1'b0;
      popCount = 0;
      driveLinks(ST_RESET,    ST_TRAINERROR); idle(1);
      driveLinks(ST_SBINIT,   ST_TRAINERROR); idle(1);
      driveLinks(ST_MBINIT,   ST_TRAINERROR); idle(1);
      driveLinks(ST_MBTRAIN,  ST_TRAINERROR); idle(1);
      driveLinks(ST_LINKINIT, ST_TRAINERROR, 1'b0); idle(1);
      driveLinks(ST_ACTIVE,   ST_TRAINERROR);
      idle(3);
      #1 check("ovf_flag", 32'(evtIf.evt_overflow_o), 32'd1);
      check("ovf_valid", 32'(evtIf.evt_valid_o), 32'd1);
      check("ovf_no_pops", 32'(popCount), 32'd0);
      @(negedge clk_100MHz);
      evtIf.evt_ready_i = 1'b1;
      waitDrain("ovf_drain", 40);
      check("ovf_events", 32'(popCount), 32'd5);

      // Async reset mid-drain
      @(negedge clk_100MHz);
      evtIf.evt_ready_i = 1'b0;
      driveLinks(ST_RESET,  ST_TRAINERROR); idle(1);
      driveLinks(ST_SBINIT, ST_TRAINERROR); idle(1);
      driveLinks(ST_MBINIT, ST_TRAINERROR); idle(3);
      @(negedge clk_100MHz);
      evtIf.evt_ready_i = 1'b1;
      @(negedge clk_100MHz);
      #1 reset = 1'b1;
      expQ.delete();
      tbPrev[0] = ST_NONE;
      tbPrev[1] = ST_NONE;
      #1;
      check("arst_valid", 32'(evtIf.evt_valid_o), 32'd0);
      checkFlags("arst", 2'b00, 2'b00, 2'b00, 1'b0);
      @(negedge clk_100MHz);
      reset = 1'b0;
      expectRelog();
      begin
         int n = 0;
         while (!evtIf.evt_valid_o && n < 10) begin
            @(negedge clk_100MHz);
            n++;
         end
      end
      #1 check("arst_first_valid", 32'(evtIf.evt_valid_o), 32'd1);
      check("arst_first_time", 32'(evtIf.evt_time_o), 32'd0);
      check("arst_first_link", 32'(evtIf.evt_link_o), 32'd0);
      waitDrain("final_drain", 20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
